// File: rtl/pingpong_fmap_buffer_if.sv
// Producer/consumer bus of the ping-pong feature-map buffer.
// master: the side that streams pixel words in and issues reads/releases.
// slave:  the buffer itself.
interface pingpong_fmap_buffer_if #(
  parameter int DW     = 16,
  parameter int CH     = 64,
  parameter int ADDR_W = 14
);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [DW*CH-1:0]     wr_data;
  logic                 wr_frame_done;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_valid;
  logic [DW*CH-1:0]     rd_data;
  logic                 rd_avail;
  logic                 rd_release;
  logic                 rd_err;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_frame_done, rd_valid, rd_data, rd_avail, rd_err
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr, rd_release,
    output wr_ready, wr_frame_done, rd_valid, rd_data, rd_avail, rd_err
  );

endinterface

// File: rtl/pingpong_fmap_buffer.sv
// Double-buffered feature-map store between two CNN layers.
// The producer fills one bank in raster order while the consumer reads the
// other, completed bank at random addresses. A bank cycles
// EMPTY -> FILLING -> FULL -> EMPTY; the writer and reader each own a bank
// pointer that toggles when they finish with their bank.
// Optional feature: define PINGPONG_STATS_EN to add frame_cnt/stall_cnt ports.
module pingpong_fmap_buffer #(
  parameter int DW     = 16,
  parameter int CH     = 64,
  parameter int MAP_H  = 111,
  parameter int MAP_W  = 111,
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  pingpong_fmap_buffer_if.slave bus
`ifdef PINGPONG_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int N      = MAP_H * MAP_W;
  localparam int WW     = DW * CH;
  localparam int MEM_AW = $clog2(2 * N);

  // Address compares are done one bit wider so N == 2**ADDR_W still works.
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_EXT      = (ADDR_W + 1)'(N);
  localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(N);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

  bank_state_e          bank_state_q [2];
  bank_state_e          bank_state_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 wr_frame_done_q, wr_frame_done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q, rd_err_d;
  logic [WW-1:0]        rd_data_q;

  logic                 wr_ready;
  logic                 rd_avail;
  logic                 wr_fire;
  logic                 wr_last;
  logic                 rd_in_range;
  logic                 rd_fire;
  logic                 rel_fire;
  logic [MEM_AW-1:0]    wr_mem_addr;
  logic [MEM_AW-1:0]    rd_mem_addr;

  // Both banks live in one array; bank 1 starts at word N.
  logic [WW-1:0]        mem [2*N];

`ifdef PINGPONG_STATS_EN
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
`endif

  // Handshake decode: which transfers actually happen this cycle.
  always_comb begin
    wr_ready    = (bank_state_q[wr_bank_q] != BANK_FULL);
    rd_avail    = (bank_state_q[rd_bank_q] == BANK_FULL);
    wr_fire     = bus.wr_valid & wr_ready;
    wr_last     = (wr_addr_q == LAST_ADDR);
    rd_in_range = ({1'b0, bus.rd_addr} < N_EXT);
    rd_fire     = bus.rd_en & rd_avail & rd_in_range;
    rel_fire    = bus.rd_release & rd_avail;
    wr_mem_addr = (wr_bank_q ? BANK1_BASE : '0) + MEM_AW'(wr_addr_q);
    rd_mem_addr = (rd_bank_q ? BANK1_BASE : '0) + MEM_AW'(bus.rd_addr);
  end

  // Next-state of the bank FSMs and pointers. A release only ever targets a
  // FULL bank and a write only a non-FULL bank, so both may apply together.
  always_comb begin
    bank_state_d[0] = bank_state_q[0];
    bank_state_d[1] = bank_state_q[1];
    wr_bank_d       = wr_bank_q;
    wr_addr_d       = wr_addr_q;
    rd_bank_d       = rd_bank_q;
    wr_frame_done_d = 1'b0;
    rd_valid_d      = rd_fire;
    rd_err_d        = rd_err_q | (bus.rd_en & ~rd_fire);

    if (wr_fire) begin
      if (wr_last) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        wr_addr_d               = '0;
        wr_bank_d               = ~wr_bank_q;
        wr_frame_done_d         = 1'b1;
      end else begin
        bank_state_d[wr_bank_q] = BANK_FILLING;
        wr_addr_d               = wr_addr_q + 1'b1;
      end
    end

    if (rel_fire) begin
      bank_state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d               = ~rd_bank_q;
    end
  end

`ifdef PINGPONG_STATS_EN
  // Frame counter wraps naturally; stall counter sticks at all-ones.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, wr_fire & wr_last};
    stall_cnt_d = stall_cnt_q;
    if (bus.wr_valid && !wr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  // Control state: bank FSMs, pointers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      wr_bank_q       <= 1'b0;
      wr_addr_q       <= '0;
      rd_bank_q       <= 1'b0;
      wr_frame_done_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
      wr_bank_q       <= wr_bank_d;
      wr_addr_q       <= wr_addr_d;
      rd_bank_q       <= rd_bank_d;
      wr_frame_done_q <= wr_frame_done_d;
      rd_valid_q      <= rd_valid_d;
      rd_err_q        <= rd_err_d;
    end
  end

  // RAM write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_mem_addr] <= bus.wr_data;
    end
  end

  // RAM read port with output register; holds its value on rejected reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_mem_addr];
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.wr_frame_done = wr_frame_done_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_err        = rd_err_q;
  assign bus.rd_data       = rd_data_q;

endmodule
